unpacker_right: RTL and testbench
=================================

# unpacker_right

Wide-to-narrow data unpacker: accepts `IN_WIDTH`-bit packed words and emits them as a stream of `OUT_WIDTH`-bit slices, least-significant slice first. It is the read-side counterpart of the narrow-to-wide packer. It sits between a wide buffer/DRAM read port and narrow PE-side consumers. A 2-entry word buffer lets a new packed word be accepted while the previous word is still being drained.

## Interface
- `IN_WIDTH`, 128: packed (wide) input word width.
- `OUT_WIDTH`, 64: unpacked (narrow) output slice width.
- Derived: `NUM = ceil(IN_WIDTH/OUT_WIDTH)`, with a minimum of 1. `SW = max(1, C_LOG_2(NUM))`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Reset`  in  1  synchronous clear; has priority over all other inputs in the same cycle.
- `Packed_EnWr`  in  1  write strobe for a wide word.
- `Packed_RdyWr`  out  1  high when the buffer holds fewer than 2 words.
- `Packed_DatWr`  in  IN_WIDTH  wide word to be unpacked.
- `Unpacked_RdyRd`  out  1  high when a slice is available.
- `Unpacked_EnRd`  in  1  read strobe; consumes the current slice.
- `Unpacked_DatRd`  out  OUT_WIDTH  current slice.
- `Unpacked_Last`  out  1  high when the current slice is slice `NUM-1` of its word.
- `Err_Ovf`  out  1  sticky flag: `Packed_EnWr` was asserted while `Packed_RdyWr` was low.

## Operation
- **Storage:** 2 word registers, 1-bit write pointer `wp`, 1-bit read pointer `rp`, 2-bit occupancy `occ` (range 0..2), slice counter `sc` of `SW` bits.
- **Write:** `Packed_EnWr && Packed_RdyWr` stores `Packed_DatWr` at `wp`, toggles `wp`, and increments `occ`.
- **Ignored write:** `Packed_EnWr` while `Packed_RdyWr` is low changes no data and sets `Err_Ovf`.
- **Slice output:** `Unpacked_DatRd = word[rp][sc*OUT_WIDTH +: OUT_WIDTH]`.
  - If `IN_WIDTH` is not a multiple of `OUT_WIDTH`, the unused upper bits of the last slice read as 0.
- **Read:** `Unpacked_EnRd && Unpacked_RdyRd`:
  - if `sc < NUM-1`, increment `sc`;
  - otherwise set `sc` to 0, toggle `rp`, and decrement `occ` (the word is popped).
- **Ignored read:** `Unpacked_EnRd` while `Unpacked_RdyRd` is low has no effect.
- **Simultaneous write and final-slice pop:** `occ` is unchanged; both pointers advance.
- **No bypass:** `Packed_RdyWr` is decoded from registered `occ` only. When `occ==2`, a write is refused even if a pop happens in the same cycle.
- **NUM==1:** every accepted read pops a word, `Unpacked_Last` is constantly 1 whenever `Unpacked_RdyRd` is high, and `sc` stays at 0.
- **Flag decodes:**
  - `Unpacked_RdyRd = (occ != 0)`;
  - `Unpacked_Last = Unpacked_RdyRd && (sc == NUM-1)`.
- **`Reset`:** zeroes `occ`, `wp`, `rp`, `sc` and `Err_Ovf`; any same-cycle strobes are dropped. Word registers are not cleared, but `Unpacked_DatRd` is don't-care while `Unpacked_RdyRd` is low.
- **`rst_n` low:** clears all registers, including the word registers, to 0.

## Timing
- Values while in reset (`rst_n` low): `Packed_RdyWr=1`, `Unpacked_RdyRd=0`, `Unpacked_Last=0`, `Unpacked_DatRd=0`, `Err_Ovf=0`.
- Write-to-read latency is 1 cycle: a word accepted at edge N is visible as slice 0 with `Unpacked_RdyRd=1` after edge N.
- `Unpacked_DatRd` is combinational from registers (first-word-fall-through), so a consumer may sample and strobe in the same cycle.
- Sustained throughput is 1 slice per cycle. For `NUM>=2`, the writer sees `Packed_RdyWr` high at least once every `NUM` cycles, so it never stalls the reader.
- `Packed_RdyWr` falls the cycle after the 2nd unpopped word is accepted. It rises the cycle after a final-slice pop that leaves `occ=1`.
- Asserting `rst_n` low mid-stream clears state immediately (asynchronously). The first write after release behaves as if into an empty buffer.

## Test plan
- **Single word, IN=128/OUT=64:** write `0xAAAA_..._BBBB` (upper 64 bits = `0xAAAA…`, lower = `0xBBBB…`), then strobe reads every cycle → `Unpacked_DatRd` = lower half with `Last=0`, then upper half with `Last=1`, then `Unpacked_RdyRd=0`.
- **Streaming:** write 4 words (values 1..4 in the low half, 0x10..0x40 in the high half) whenever `Packed_RdyWr` is high, with `Unpacked_EnRd` held at 1 → slices 1,0x10,2,0x20,3,0x30,4,0x40 with no bubble after the first slice; `Err_Ovf` stays 0.
- **Full/overflow:** write 2 words with no reads → `Packed_RdyWr=0`; write a 3rd word → data ignored, `Err_Ovf=1`; then read 4 slices → only the first 2 words appear, and `Packed_RdyWr=1` after the 2nd slice is read.
- **Simultaneous write and pop:** with `occ=1` and `sc=1`, assert write and read in the same cycle → `occ` stays 1, and the next slice is slice 0 of the new word.
- **Non-multiple widths, IN=96/OUT=64:** write `0x123456789ABCDEF0_11223344` → slices `0x9ABCDEF0_11223344`, then `0x00000000_12345678` with `Last=1`.
- **Reset mid-operation:** after one slice has been read, pulse `Reset` together with `Packed_EnWr` → `occ=0`, `sc=0`, `Unpacked_RdyRd=0`, and the word is dropped. Repeat the check with `rst_n` pulsed low → all outputs return to their reset values.

Source files
------------

// File: rtl/unpacker_right.sv
// unpacker_right: wide-to-narrow unpacker with a 2-entry word buffer.
// Accepts IN_WIDTH-bit words and emits OUT_WIDTH-bit slices, LS slice first.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   Reset           sync clear of pointers/occupancy/error (priority)
//   Packed_EnWr     write strobe; Packed_DatWr wide word; Packed_RdyWr buffer not full
//   Unpacked_EnRd   read strobe; Unpacked_DatRd current slice; Unpacked_RdyRd slice valid
//   Unpacked_Last   current slice is the last one of its word
//   Err_Ovf         sticky: write attempted while full
module unpacker_right #(
   parameter int unsigned IN_WIDTH  = 128,
   parameter int unsigned OUT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Reset,
   input  logic                 Packed_EnWr,
   output logic                 Packed_RdyWr,
   input  logic [IN_WIDTH-1:0]  Packed_DatWr,
   output logic                 Unpacked_RdyRd,
   input  logic                 Unpacked_EnRd,
   output logic [OUT_WIDTH-1:0] Unpacked_DatRd,
   output logic                 Unpacked_Last,
   output logic                 Err_Ovf
);

   localparam int unsigned NUM_RAW = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int unsigned NUM     = (NUM_RAW < 1) ? 1 : NUM_RAW;
   localparam int unsigned SW      = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int unsigned PW      = NUM * OUT_WIDTH;
   localparam logic [SW-1:0] SC_LAST = SW'(NUM - 1);

   logic [IN_WIDTH-1:0] word_q [2];
   logic [IN_WIDTH-1:0] word_d [2];
   logic                wp_q, wp_d;
   logic                rp_q, rp_d;
   logic [1:0]          occ_q, occ_d;
   logic [SW-1:0]       sc_q, sc_d;
   logic                ovf_q, ovf_d;

   logic                wr_ok, rd_ok, pop;
   logic [PW-1:0]       padded;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q[0] <= '0;
         word_q[1] <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         occ_q     <= 2'd0;
         sc_q      <= '0;
         ovf_q     <= 1'b0;
      end else begin
         word_q[0] <= word_d[0];
         word_q[1] <= word_d[1];
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         occ_q     <= occ_d;
         sc_q      <= sc_d;
         ovf_q     <= ovf_d;
      end
   end

   // Handshake qualification; readiness comes from registered occupancy only
   assign wr_ok = Packed_EnWr   && (occ_q != 2'd2);
   assign rd_ok = Unpacked_EnRd && (occ_q != 2'd0);
   assign pop   = rd_ok && (sc_q == SC_LAST);

   // Next-state logic
   always_comb begin
      word_d[0] = word_q[0];
      word_d[1] = word_q[1];
      wp_d      = wp_q;
      rp_d      = rp_q;
      occ_d     = occ_q;
      sc_d      = sc_q;
      ovf_d     = ovf_q;

      if (Reset) begin
         wp_d  = 1'b0;
         rp_d  = 1'b0;
         occ_d = 2'd0;
         sc_d  = '0;
         ovf_d = 1'b0;
      end else begin
         if (wr_ok) begin
            word_d[wp_q] = Packed_DatWr;
            wp_d         = ~wp_q;
         end
         if (Packed_EnWr && !wr_ok) begin
            ovf_d = 1'b1;
         end
         if (rd_ok) begin
            if (pop) begin
               sc_d = '0;
               rp_d = ~rp_q;
            end else begin
               sc_d = sc_q + SW'(1);
            end
         end
         case ({wr_ok, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // Zero-extend so a short final slice reads 0 in its unused upper bits
   assign padded = PW'(word_q[rp_q]);

   // Slice select; loop keeps the index within NUM slices
   always_comb begin
      Unpacked_DatRd = '0;
      for (int unsigned i = 0; i < NUM; i++) begin
         if (sc_q == SW'(i)) begin
            Unpacked_DatRd = padded[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   assign Packed_RdyWr   = (occ_q != 2'd2);
   assign Unpacked_RdyRd = (occ_q != 2'd0);
   assign Unpacked_Last  = Unpacked_RdyRd && (sc_q == SC_LAST);
   assign Err_Ovf        = ovf_q;

endmodule

// File: tb/tb_unpacker_right.sv
// Directed bench for unpacker_right: one 128/64 instance and one 96/64 instance.
module tb_unpacker_right;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         reset = 1'b0;
   logic         wr = 1'b0;
   logic [127:0] din = '0;
   logic         rd = 1'b0;
   logic         rdy_wr, rdy_rd, last, ovf;
   logic [63:0]  dat;

   logic         wr2 = 1'b0;
   logic [95:0]  din2 = '0;
   logic         rd2 = 1'b0;
   logic         reset2 = 1'b0;
   logic         rdy_wr2, rdy_rd2, last2, ovf2;
   logic [63:0]  dat2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   unpacker_right #(.IN_WIDTH(128), .OUT_WIDTH(64)) u_dut (
      .clk(clk), .rst_n(rst_n), .Reset(reset),
      .Packed_EnWr(wr), .Packed_RdyWr(rdy_wr), .Packed_DatWr(din),
      .Unpacked_RdyRd(rdy_rd), .Unpacked_EnRd(rd), .Unpacked_DatRd(dat),
      .Unpacked_Last(last), .Err_Ovf(ovf)
   );

   unpacker_right #(.IN_WIDTH(96), .OUT_WIDTH(64)) u_dut96 (
      .clk(clk), .rst_n(rst_n), .Reset(reset2),
      .Packed_EnWr(wr2), .Packed_RdyWr(rdy_wr2), .Packed_DatWr(din2),
      .Unpacked_RdyRd(rdy_rd2), .Unpacked_EnRd(rd2), .Unpacked_DatRd(dat2),
      .Unpacked_Last(last2), .Err_Ovf(ovf2)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock; outputs are observed 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] sword(input int k);
      return {64'((k + 1) * 16), 64'(k + 1)};
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_s [8];
      int          k, idx;
      logic        started;

      // Reset values
      #2;
      check("rst_rdywr", 128'(rdy_wr), 128'(1'b1));
      check("rst_rdyrd", 128'(rdy_rd), 128'(1'b0));
      check("rst_last",  128'(last),   128'(1'b0));
      check("rst_dat",   128'(dat),    128'(64'h0));
      check("rst_ovf",   128'(ovf),    128'(1'b0));
      rst_n = 1'b1;

      // Single word
      wr = 1'b1; din = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
      step();
      wr = 1'b0;
      check("single_rdy",   128'(rdy_rd), 128'(1'b1));
      check("single_lo",    128'(dat),    128'(64'hBBBB_BBBB_BBBB_BBBB));
      check("single_lo_lst",128'(last),   128'(1'b0));
      rd = 1'b1;
      step();
      check("single_hi",    128'(dat),    128'(64'hAAAA_AAAA_AAAA_AAAA));
      check("single_hi_lst",128'(last),   128'(1'b1));
      step();
      rd = 1'b0;
      check("single_empty", 128'(rdy_rd), 128'(1'b0));
      check("single_rdywr", 128'(rdy_wr), 128'(1'b1));

      // Streaming with reads held high
      for (int i = 0; i < 4; i++) begin
         exp_s[2*i]   = 64'(i + 1);
         exp_s[2*i+1] = 64'((i + 1) * 16);
      end
      k = 0; idx = 0; started = 1'b0;
      rd = 1'b1;
      for (int cyc = 0; cyc < 24 && idx < 8; cyc++) begin
         if (rdy_rd) begin
            check($sformatf("stream_s%0d", idx), 128'(dat), 128'(exp_s[idx]));
            idx++;
            started = 1'b1;
         end else if (started) begin
            check("stream_bubble", 128'(rdy_rd), 128'(1'b1));
         end
         wr  = rdy_wr && (k < 4);
         din = sword(k);
         if (wr) k++;
         step();
      end
      wr = 1'b0; rd = 1'b0;
      check("stream_count", 128'(idx),    128'(8));
      check("stream_empty", 128'(rdy_rd), 128'(1'b0));
      check("stream_ovf",   128'(ovf),    128'(1'b0));

      // Full / overflow
      wr = 1'b1; din = {64'h1111, 64'h1000};
      step();
      din = {64'h2222, 64'h2000};
      step();
      wr = 1'b0;
      check("full_rdywr", 128'(rdy_wr), 128'(1'b0));
      check("full_ovf0",  128'(ovf),    128'(1'b0));
      wr = 1'b1; din = {64'h3333, 64'h3000};
      step();
      wr = 1'b0;
      check("ovf_set",    128'(ovf),    128'(1'b1));
      check("ovf_rdywr",  128'(rdy_wr), 128'(1'b0));
      rd = 1'b1;
      check("ovf_s0", 128'(dat), 128'(64'h1000));
      step();
      check("ovf_s1", 128'(dat), 128'(64'h1111));
      check("ovf_s1_rdywr", 128'(rdy_wr), 128'(1'b0));
      step();
      check("ovf_pop_rdywr", 128'(rdy_wr), 128'(1'b1));
      check("ovf_s2", 128'(dat), 128'(64'h2000));
      step();
      check("ovf_s3", 128'(dat), 128'(64'h2222));
      check("ovf_s3_last", 128'(last), 128'(1'b1));
      step();
      rd = 1'b0;
      check("ovf_empty", 128'(rdy_rd), 128'(1'b0));
      check("ovf_sticky", 128'(ovf), 128'(1'b1));

      // Sync Reset clears the sticky error
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("sreset_ovf", 128'(ovf), 128'(1'b0));

      // Simultaneous write and final-slice pop
      wr = 1'b1; din = {64'hA1A1, 64'hA0A0};
      step();
      wr = 1'b0; rd = 1'b1;
      step();
      wr = 1'b1; din = {64'hB1B1, 64'hB0B0};
      check("sim_a_hi",   128'(dat),  128'(64'hA1A1));
      check("sim_a_last", 128'(last), 128'(1'b1));
      step();
      wr = 1'b0; rd = 1'b0;
      check("sim_rdyrd",  128'(rdy_rd), 128'(1'b1));
      check("sim_rdywr",  128'(rdy_wr), 128'(1'b1));
      check("sim_b_lo",   128'(dat),    128'(64'hB0B0));
      check("sim_b_last", 128'(last),   128'(1'b0));
      rd = 1'b1;
      step();
      step();
      rd = 1'b0;
      check("sim_drained", 128'(rdy_rd), 128'(1'b1 ^ 1'b1));

      // Sync Reset mid-word drops the word and the same-cycle write
      wr = 1'b1; din = {64'hC1C1, 64'hC0C0};
      step();
      wr = 1'b0; rd = 1'b1;
      step();
      rd = 1'b0;
      reset = 1'b1; wr = 1'b1; din = {64'hD1D1, 64'hD0D0};
      step();
      reset = 1'b0; wr = 1'b0;
      check("rmid_rdyrd", 128'(rdy_rd), 128'(1'b0));
      check("rmid_last",  128'(last),   128'(1'b0));
      check("rmid_rdywr", 128'(rdy_wr), 128'(1'b1));
      wr = 1'b1; din = {64'hE1E1, 64'hE0E0};
      step();
      wr = 1'b0;
      check("rmid_e_lo",   128'(dat),  128'(64'hE0E0));
      check("rmid_e_last", 128'(last), 128'(1'b0));

      // Async reset mid-stream with the buffer full
      wr = 1'b1; din = {64'hF1F1, 64'hF0F0};
      step();
      wr = 1'b0;
      rst_n = 1'b0;
      #2;
      check("arst_rdywr", 128'(rdy_wr), 128'(1'b1));
      check("arst_rdyrd", 128'(rdy_rd), 128'(1'b0));
      check("arst_last",  128'(last),   128'(1'b0));
      check("arst_dat",   128'(dat),    128'(64'h0));
      check("arst_ovf",   128'(ovf),    128'(1'b0));
      rst_n = 1'b1;
      step();
      wr = 1'b1; din = {64'h6161, 64'h6060};
      step();
      wr = 1'b0;
      check("arst_g_lo",   128'(dat),    128'(64'h6060));
      check("arst_g_rdy",  128'(rdy_rd), 128'(1'b1));
      check("arst_g_wr",   128'(rdy_wr), 128'(1'b1));

      // Non-multiple widths: 96-bit word into 64-bit slices
      wr2 = 1'b1; din2 = 96'h123456789ABCDEF0_11223344;
      step();
      wr2 = 1'b0;
      check("w96_s0",      128'(dat2),  128'(64'h9ABCDEF0_11223344));
      check("w96_s0_last", 128'(last2), 128'(1'b0));
      rd2 = 1'b1;
      step();
      check("w96_s1",      128'(dat2),  128'(64'h00000000_12345678));
      check("w96_s1_last", 128'(last2), 128'(1'b1));
      step();
      rd2 = 1'b0;
      check("w96_empty",   128'(rdy_rd2), 128'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
